// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit queue: FSM states,
// per-entry commit metadata and the GPR count.
package difftest_pkg;

    localparam int NR_GPR = 32;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  waddr;
    } commit_entry_t;

endpackage

// File: rtl/difftest_dpi_sink.sv
// Difftest consumer: reports each dequeued commit with the updated GPR file.
// Compiled only when DIFFTEST_DPI_EN is defined.
`ifdef DIFFTEST_DPI_EN
module difftest_dpi_sink
  import difftest_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   deq,
  input  logic [XLEN-1:0]        pc,
  input  logic [31:0]            inst,
  input  logic [NR_GPR*XLEN-1:0] gpr,
  input  logic                   done
);

  logic            deq_q;
  logic            done_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      deq_q  <= 1'b0;
      done_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else begin
      deq_q  <= deq;
      done_q <= done;
      pc_q   <= pc;
      inst_q <= inst;
      if (deq_q) begin
        $display("difftest step pc=%h inst=%h",
                 pc_q, inst_q);
        for (int i = 0; i < NR_GPR; i++)
          $display("difftest gpr x%0d=%h",
                   i, gpr[i*XLEN +: XLEN]);
      end
      if (done && !done_q)
        $display("difftest trap done");
    end
  end

endmodule
`endif

// File: rtl/difftest_commit_queue.sv
// Multi-lane commit queue feeding a difftest checker with a shadow GPR file.
// Define DIFFTEST_DPI_EN to attach the internal DPI sink.
module difftest_commit_queue
    import difftest_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NR_COMMIT = 2,
    parameter int DEPTH     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NR_COMMIT-1:0]    cmt_valid,
    input  logic [NR_COMMIT*XLEN-1:0] cmt_pc,
    input  logic [NR_COMMIT*32-1:0] cmt_inst,
    input  logic [NR_COMMIT-1:0]    cmt_wen,
    input  logic [NR_COMMIT*5-1:0]  cmt_waddr,
    input  logic [NR_COMMIT*XLEN-1:0] cmt_wdata,
    input  logic                    trap,
    input  logic                    sink_ready,
    output logic                    out_valid,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_inst,
    output logic                    out_wen,
    output logic [4:0]              out_waddr,
    output logic [XLEN-1:0]         out_wdata,
    output logic [NR_GPR*XLEN-1:0]  shadow_gpr,
    output logic                    stall_req,
    output logic                    overflow,
    output logic                    done,
    output logic [63:0]             retired
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] NRC_P   = PW'(NR_COMMIT);

    typedef struct packed {
        commit_entry_t   meta;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] wdata;
    } slot_t;

    slot_t mem [DEPTH];
    slot_t head;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] level, level_d, free_d, n_enq;
    logic [PW-1:0] off [NR_COMMIT];
    logic          empty, accept, drop, deq, sink_rdy;
    state_t        state, state_d;
    logic [NR_GPR-1:0][XLEN-1:0] gpr;

    assign level     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_pc    = head.pc;
    assign out_inst  = head.meta.inst;
    assign out_wen   = head.meta.wen;
    assign out_waddr = head.meta.waddr;
    assign out_wdata = head.wdata;
    assign deq       = out_valid && sink_rdy;
    assign shadow_gpr = gpr;
    assign done      = (state == DONE);

    // Each valid lane lands at its rank among the valid lanes.
    always_comb begin
        n_enq = '0;
        for (int l = 0; l < NR_COMMIT; l++) begin
            off[l] = n_enq;
            n_enq  = n_enq + PW'(cmt_valid[l]);
        end
    end

    assign accept  = (state == RUN) && (n_enq != '0)
                   && ((DEPTH_P - level) >= n_enq);
    assign drop    = (state == RUN) && ((DEPTH_P - level) < n_enq);
    assign level_d = level + (accept ? n_enq : '0) - PW'(deq);
    assign free_d  = DEPTH_P - level_d;

    always_comb begin
        state_d = state;
        case (state)
            RUN:     if (trap) state_d = DRAIN;
            DRAIN:   if (empty) state_d = DONE;
            default: state_d = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= RUN;
            gpr       <= '0;
            retired   <= '0;
            overflow  <= 1'b0;
            stall_req <= 1'b0;
        end else begin
            state <= state_d;
            if (accept)
                wr_ptr <= wr_ptr + n_enq;
            if (deq) begin
                rd_ptr  <= rd_ptr + PW'(1);
                retired <= retired + 64'd1;
                if (head.meta.wen && head.meta.waddr != 5'd0)
                    gpr[head.meta.waddr] <= head.wdata;
            end
            if (drop)
                overflow <= 1'b1;
            stall_req <= (free_d < NRC_P);
        end
    end

    always_ff @(posedge clock) begin
        for (int l = 0; l < NR_COMMIT; l++) begin
            if (accept && cmt_valid[l]) begin
                mem[wr_ptr[AW-1:0] + off[l][AW-1:0]] <= '{
                    meta:  '{inst:  cmt_inst[l*32 +: 32],
                             wen:   cmt_wen[l],
                             waddr: cmt_waddr[l*5 +: 5]},
                    pc:    cmt_pc[l*XLEN +: XLEN],
                    wdata: cmt_wdata[l*XLEN +: XLEN]
                };
            end
        end
    end

`ifdef DIFFTEST_DPI_EN
    assign sink_rdy = 1'b1;

    difftest_dpi_sink #(
        .XLEN(XLEN)
    ) u_sink (
        .clock (clock),
        .reset (reset),
        .deq   (deq),
        .pc    (out_pc),
        .inst  (out_inst),
        .gpr   (shadow_gpr),
        .done  (done)
    );
`else
    assign sink_rdy = sink_ready;
`endif

endmodule
